// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcode, funct and ALU opselect encodings shared by the issue stage and the ALU
package alu_issue_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLTU = 5'b00010;
    localparam logic [4:0] ALU_SRAV = 5'b00011;
    localparam logic [4:0] ALU_SLLV = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_BGTZ = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_AND  = 5'b01001;
    localparam logic [4:0] ALU_OR   = 5'b01010;
    localparam logic [4:0] ALU_SRA  = 5'b01011;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SRLV = 5'b01110;
    localparam logic [4:0] ALU_SRL  = 5'b01111;
    localparam logic [4:0] ALU_BLEZ = 5'b10000;
    localparam logic [4:0] ALU_BNE  = 5'b10010;

    typedef struct packed {
        logic [4:0]  opselect;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic        is_branch;
        logic        illegal;
    } issue_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0, v};
    endfunction
endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_decode: combinational MIPS instruction to ALU operation/operand decode
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [4:0]  opselect,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [4:0]  shamt,
    output logic [4:0]  dest,
    output logic        is_branch,
    output logic        illegal
);
    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd, sa;
    logic [15:0] imm;
    logic        legal;
    logic        unused_rs;
    issue_t      d;

    assign opcode    = instr[31:26];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign sa        = instr[10:6];
    assign funct     = instr[5:0];
    assign imm       = instr[15:0];
    assign unused_rs = ^instr[25:21];

    always_comb begin
        d = '0;
        legal = 1'b1;
        d.x = rs_val;
        case (opcode)
            OP_RTYPE: begin
                d.dest = rd;
                d.y = rt_val;
                case (funct)
                    F_ADD, F_ADDU: d.opselect = ALU_ADD;
                    F_SUB, F_SUBU: d.opselect = ALU_SUB;
                    F_AND:  d.opselect = ALU_AND;
                    F_OR:   d.opselect = ALU_OR;
                    F_XOR:  d.opselect = ALU_XOR;
                    F_NOR:  d.opselect = ALU_NOR;
                    F_SLT:  d.opselect = ALU_SLT;
                    F_SLTU: d.opselect = ALU_SLTU;
                    F_SLL, F_SRL, F_SRA: begin
                        d.opselect = funct == F_SLL ? ALU_SLL : funct == F_SRL ? ALU_SRL : ALU_SRA;
                        d.x = rt_val;
                        d.y = '0;
                        d.shamt = sa;
                    end
                    F_SLLV, F_SRLV, F_SRAV: begin
                        d.opselect = funct == F_SLLV ? ALU_SLLV : funct == F_SRLV ? ALU_SRLV : ALU_SRAV;
                        d.x = rt_val;
                        d.y = rs_val;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_SLTI, OP_SLTIU: begin
                d.opselect = opcode == OP_SLTI ? ALU_SLT : opcode == OP_SLTIU ? ALU_SLTU : ALU_ADD;
                d.y = sext16(imm);
                d.dest = opcode == OP_SW ? 5'd0 : rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                d.opselect = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_XOR;
                d.y = zext16(imm);
                d.dest = rt;
            end
            OP_LUI: begin
                d.opselect = ALU_SLL;
                d.x = zext16(imm);
                d.shamt = 5'd16;
                d.dest = rt;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                d.opselect = opcode == OP_BEQ ? ALU_SUB : opcode == OP_BNE ? ALU_BNE :
                             opcode == OP_BLEZ ? ALU_BLEZ : ALU_BGTZ;
                d.y = (opcode == OP_BEQ || opcode == OP_BNE) ? rt_val : 32'h0;
                d.is_branch = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) d = '0;
        d.illegal = !legal;
    end

    assign opselect  = d.opselect;
    assign x         = d.x;
    assign y         = d.y;
    assign shamt     = d.shamt;
    assign dest      = d.dest;
    assign is_branch = d.is_branch;
    assign illegal   = d.illegal;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes instructions into a two-entry skid buffer feeding the ALU
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  opselect,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [4:0]  shamt,
    output logic [4:0]  dest,
    output logic        is_branch,
    output logic        illegal
);
    issue_t dec, main_q, skid_q;
    logic   main_valid, skid_valid, accept;

    alu_decode u_decode (
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .opselect  (dec.opselect),
        .x         (dec.x),
        .y         (dec.y),
        .shamt     (dec.shamt),
        .dest      (dec.dest),
        .is_branch (dec.is_branch),
        .illegal   (dec.illegal)
    );

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    // The skid entry only fills while main is stalled, so it always holds the younger entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid || out_ready) begin
            main_valid <= skid_valid || accept;
            skid_valid <= 1'b0;
            if (skid_valid) main_q <= skid_q;
            else if (accept) main_q <= dec;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_q     <= dec;
        end
    end

    assign out_valid = main_valid;
    assign opselect  = main_q.opselect;
    assign x         = main_q.x;
    assign y         = main_q.y;
    assign shamt     = main_q.shamt;
    assign dest      = main_q.dest;
    assign is_branch = main_q.is_branch;
    assign illegal   = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with a queue scoreboard checked by a negedge monitor
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, is_branch, illegal;
    logic [31:0] instr, rs_val, rt_val, x, y;
    logic [4:0]  opselect, shamt, dest;
    logic [80:0] exp_cur;
    logic [80:0] sb[$];
    int          n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opselect(opselect), .x(x), .y(y), .shamt(shamt),
        .dest(dest), .is_branch(is_branch), .illegal(illegal)
    );

    function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] ex, input logic [31:0] ey,
                                       input logic [4:0] sh, input logic [4:0] d, input logic br, input logic il);
        return {op, ex, ey, sh, d, br, il};
    endfunction

    task automatic check(input string name, input logic [80:0] got, input logic [80:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Scoreboard: pushes on each observed accept, pops and compares on each issue.
    always @(negedge clk) begin
        if (rst || flush) sb.delete();
        else begin
            if (out_valid) begin
                if (sb.size() == 0) check("unexpected_out", 81'(out_valid), 81'd0);
                else if (out_ready) check("issue", {opselect, x, y, shamt, dest, is_branch, illegal}, sb.pop_front());
                else check("hold", {opselect, x, y, shamt, dest, is_branch, illegal}, sb[0]);
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic [80:0] e);
        instr = i; rs_val = a; rt_val = b; exp_cur = e; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 81'(in_ready), 81'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; rs_val = '0; rt_val = '0; exp_cur = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 81'(out_valid), 81'd0);
        check("reset_in_ready", 81'(in_ready), 81'd1);
        check("reset_fields", {opselect, x, y, shamt, dest, is_branch, illegal}, 81'd0);
        @(posedge clk); #1;

        send(32'h2108FFFF, 32'd5, 32'h77, mk(5'b00000, 32'd5, 32'hFFFFFFFF, 5'd0, 5'd8, 1'b0, 1'b0));
        @(negedge clk);
        check("addi_latency", 81'(out_valid), 81'd1);
        @(posedge clk); #1;
        send(32'h3C011234, 32'h99, 32'h0, mk(5'b00101, 32'h1234, 32'h0, 5'd16, 5'd1, 1'b0, 1'b0));
        send(32'h00221820, 32'd10, 32'd20, mk(5'b00000, 32'd10, 32'd20, 5'd0, 5'd3, 1'b0, 1'b0));
        send(32'h00A62022, 32'h100, 32'd1, mk(5'b00001, 32'h100, 32'd1, 5'd0, 5'd4, 1'b0, 1'b0));
        send(32'h000838C0, 32'hAA, 32'hF0, mk(5'b00101, 32'hF0, 32'h0, 5'd3, 5'd7, 1'b0, 1'b0));
        send(32'h016A4804, 32'd2, 32'h11, mk(5'b00100, 32'h11, 32'd2, 5'd0, 5'd9, 1'b0, 1'b0));
        send(32'h0000003F, 32'd1, 32'd2, mk(5'b00000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1));
        send(32'h18400000, 32'd7, 32'd9, mk(5'b10000, 32'd7, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0));
        send(32'h00000000, 32'h33, 32'h55, mk(5'b00101, 32'h55, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0));
        send(32'h30858001, 32'hFFFF0000, 32'h1, mk(5'b01001, 32'hFFFF0000, 32'h8001, 5'd0, 5'd5, 1'b0, 1'b0));
        send(32'hAC22FFFC, 32'h1000, 32'h2, mk(5'b00000, 32'h1000, 32'hFFFFFFFC, 5'd0, 5'd0, 1'b0, 1'b0));
        send(32'h2C430005, 32'd4, 32'd6, mk(5'b00010, 32'd4, 32'd5, 5'd0, 5'd3, 1'b0, 1'b0));
        send(32'h14220003, 32'd3, 32'd4, mk(5'b10010, 32'd3, 32'd4, 5'd0, 5'd0, 1'b1, 1'b0));
        send(32'hFC000000, 32'd8, 32'd8, mk(5'b00000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1));
        send(32'h0043082A, 32'hFFFFFFFF, 32'd1, mk(5'b00111, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd1, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream_drained", 81'(sb.size()), 81'd0);

        // Three back-to-back offers into a stalled consumer.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h00221820, 32'd1, 32'd2, mk(5'b00000, 32'd1, 32'd2, 5'd0, 5'd3, 1'b0, 1'b0));
        send(32'h00A62022, 32'd9, 32'd4, mk(5'b00001, 32'd9, 32'd4, 5'd0, 5'd4, 1'b0, 1'b0));
        instr = 32'h3C01ABCD; rs_val = 32'h0; rt_val = 32'h0; in_valid = 1'b1;
        exp_cur = mk(5'b00101, 32'hABCD, 32'h0, 5'd16, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        check("full_in_ready", 81'(in_ready), 81'd0);
        check("full_out_valid", 81'(out_valid), 81'd1);
        check("full_sb_depth", 81'(sb.size()), 81'd2);
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h3C01ABCD, 32'h0, 32'h0, mk(5'b00101, 32'hABCD, 32'h0, 5'd16, 5'd1, 1'b0, 1'b0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_drained", 81'(sb.size()), 81'd0);

        // Flush during a stall drops the held bne and the same-cycle offer.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h14220003, 32'd3, 32'd4, mk(5'b10010, 32'd3, 32'd4, 5'd0, 5'd0, 1'b1, 1'b0));
        instr = 32'h38A5000F; in_valid = 1'b1; flush = 1'b1;
        exp_cur = mk(5'b01101, 32'd3, 32'hF, 5'd0, 5'd5, 1'b0, 1'b0);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 81'(out_valid), 81'd0);
        check("flush_in_ready", 81'(in_ready), 81'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("flush_no_issue", 81'(out_valid), 81'd0);

        // Reset with both entries held.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h00221820, 32'd5, 32'd6, mk(5'b00000, 32'd5, 32'd6, 5'd0, 5'd3, 1'b0, 1'b0));
        send(32'h30858001, 32'd7, 32'd0, mk(5'b01001, 32'd7, 32'h8001, 5'd0, 5'd5, 1'b0, 1'b0));
        @(negedge clk);
        check("two_held_in_ready", 81'(in_ready), 81'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 81'(out_valid), 81'd0);
        check("rst_in_ready", 81'(in_ready), 81'd1);
        check("rst_fields", {opselect, x, y, shamt, dest, is_branch, illegal}, 81'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_issue", 81'(out_valid), 81'd0);
        @(posedge clk); #1;
        send(32'h2108FFFF, 32'd1, 32'd0, mk(5'b00000, 32'd1, 32'hFFFFFFFF, 5'd0, 5'd8, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        check("final_drained", 81'(sb.size()), 81'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 The port list SHALL be as follows, one port per line, with clock and reset first:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept; registered, not combinational on out_ready
- instr  input  32  MIPS instruction word
- rs_val  input  32  register-file value of rs
- rt_val  input  32  register-file value of rt
- flush  input  1  discard all held entries (branch redirect)
- out_valid  output  1  issue entry valid toward ALU
- out_ready  input  1  ALU/EX consumer accepts
- opselect  output  5  ALU operation code
- x  output  32  ALU operand x
- y  output  32  ALU operand y
- shamt  output  5  ALU shift amount
- dest  output  5  write-back register (rd for R-type, rt for I-type, 0 for branch/store)
- is_branch  output  1  conditional branch; EX uses ALU zero/res
- illegal  output  1  opcode/funct not decodable

Function
REQ-003 A transfer SHALL occur on each side when valid and ready are both high at a rising edge.
REQ-004 Latency SHALL be one cycle: an instruction accepted at edge N SHALL be presented with out_valid=1 after edge N if the buffer was empty.
REQ-005 Buffering SHALL be a two-entry skid buffer: main register plus skid register; in_ready=1 while the skid entry is empty.
REQ-006 When the buffer is full (both entries valid), in_valid SHALL be ignored and in_ready SHALL be 0.
REQ-007 Output order SHALL equal acceptance order; outputs SHALL be held stable while out_valid=1 and out_ready=0.
REQ-008 Simultaneous accept and issue SHALL keep occupancy unchanged with no bubble.
REQ-009 flush SHALL clear both entries at the next edge and SHALL win over a same-cycle accept.
REQ-010 R-type (opcode 0) funct decode SHALL be:
- 0x20/0x21 -> 00000
- 0x22/0x23 -> 00001
- 0x24 -> 01001
- 0x25 -> 01010
- 0x26 -> 01101
- 0x27 -> 01100
- 0x2A -> 00111
- 0x2B -> 00010
- 0x00 -> 00101
- 0x02 -> 01111
- 0x03 -> 01011
- 0x04 -> 00100
- 0x06 -> 01110
- 0x07 -> 00011
REQ-011 R-type operand assignment SHALL be: shifts use x=rt_val, with y=rs_val for variable shifts and shamt=instr[10:6] otherwise; all other R-type use x=rs_val, y=rt_val.
REQ-012 I-type decode SHALL be:
- addi/addiu/lw/sw (0x08/0x09/0x23/0x2B) -> 00000, y=sign-extended imm
- slti 0x0A -> 00111, y=sign-extended imm
- sltiu 0x0B -> 00010, y=sign-extended imm
- andi/ori/xori (0x0C/0x0D/0x0E) -> 01001/01010/01101, y=zero-extended imm
- lui 0x0F -> 00101, x=zero-extended imm, shamt=16
REQ-013 Branch decode SHALL be, with is_branch=1:
- beq 0x04 -> 00001, x=rs_val, y=rt_val
- bne 0x05 -> 10010, x=rs_val, y=rt_val
- blez 0x06 -> 10000, x=rs_val, y=0
- bgtz 0x07 -> 00110, x=rs_val, y=0
REQ-014 Any undecodable opcode/funct SHALL issue with illegal=1, opselect=00000, dest=0, and x, y and shamt all 0.
REQ-015 The all-zero instruction (sll $0,$0,0) SHALL decode as a legal nop with dest=0.

Reset
REQ-016 With rst high at an edge, both entries SHALL be cleared, out_valid=0 and in_ready=1 after that edge; rst SHALL override flush and any transfer.
REQ-017 After reset, opselect, x, y, shamt, dest, is_branch and illegal SHALL all read 0.
REQ-018 Asserting rst mid-stall SHALL drop held entries without issuing them.

Structure
REQ-019 Opcode constants, funct constants and the 5-bit opselect codes SHALL live in a shared package used by both this block and the ALU.
REQ-020 Decode SHALL be a combinational sub-module alu_decode (instr, rs_val, rt_val -> opselect, x, y, shamt, dest, is_branch, illegal); the skid buffer SHALL be in alu_issue_stage.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- addi instr=0x2108FFFF, rs_val=5 -> one cycle later out_valid=1, opselect=00000, x=5, y=0xFFFFFFFF, dest=8.
- lui instr=0x3C011234 -> opselect=00101, x=0x00001234, shamt=16, dest=1.
- out_ready=0 while three instrs are offered back-to-back -> two accepted, in_ready=0 on the third; release -> issued in order, no loss.
- bne during a stall with flush pulsed -> out_valid=0 next cycle; the flush-cycle instr is not accepted.
- funct 0x3F -> illegal=1, opselect=00000; blez -> opselect=10000, y=0, is_branch=1.
- rst asserted with two entries held -> out_valid=0, in_ready=1 after one edge.
